countdown_mmss: RTL and testbench

BCD minutes:seconds countdown timer: loads a start value MM:SS, decrements once per `tick` enable pulse while running, and flags completion at 00:00. It is the down-counting counterpart of the up-counting decimal/sexagesimal counter chain in the clock datapath. Its digit outputs feed the same seven-segment display path, and its per-minute borrow pulse cascades like the up-counter's carry.

---
 rtl/timer_pkg.sv | 20 ++
 rtl/bcd_down_digit.sv | 30 +++
 rtl/countdown_mmss.sv | 93 +++++++++
 tb/tb_countdown_mmss.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared digit limits, widths and countdown state type
package timer_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] DIGIT_MAX    = 4'd9;
   localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } cd_state_t;

   function automatic logic [BCD_W-1:0] sat_digit(input logic [BCD_W-1:0] d,
                                                  input logic [BCD_W-1:0] lim);
      return (d > lim) ? lim : d;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// rtl/bcd_down_digit.sv - one BCD down-counting digit with load and borrow-out
module bcd_down_digit
   import timer_pkg::*;
#(
   parameter logic [3:0] WRAP = 4'd9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [BCD_W-1:0] load_d,
   input  logic             dec_en,
   output logic [BCD_W-1:0] digit,
   output logic             borrow
);

   localparam logic [BCD_W-1:0] ONE = 4'd1;

   assign borrow = dec_en && (digit == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= '0;
      end else if (load) begin
         digit <= load_d;
      end else if (dec_en) begin
         digit <= (digit == '0) ? WRAP : digit - ONE;
      end
   end

endmodule

// File: rtl/countdown_mmss.sv
// rtl/countdown_mmss.sv - BCD MM:SS countdown timer with run/pause control
module countdown_mmss
   import timer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tick,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        start,
   input  logic        pause,
   output logic [3:0]  min_hi,
   output logic [3:0]  min_lo,
   output logic [3:0]  sec_hi,
   output logic [3:0]  sec_lo,
   output logic        running,
   output logic        min_bo,
   output logic        done
);

   cd_state_t state, state_nx;

   logic load_en, dec;
   logic bo_sl, bo_sh, bo_ml, bo_mh;
   logic is_zero, is_one;
   logic [BCD_W-1:0] ld_mh, ld_ml, ld_sh, ld_sl;

   assign is_zero = ({min_hi, min_lo, sec_hi, sec_lo} == 16'h0000);
   assign is_one  = ({min_hi, min_lo, sec_hi, sec_lo} == 16'h0001);

   // load is never honoured while counting, so it cannot collide with dec
   assign load_en = load && (state != RUN);
   assign dec     = (state == RUN) && tick && !pause;

   assign ld_mh = sat_digit(load_val[15:12], DIGIT_MAX);
   assign ld_ml = sat_digit(load_val[11:8],  DIGIT_MAX);
   assign ld_sh = sat_digit(load_val[7:4],   SEC_TENS_MAX);
   assign ld_sl = sat_digit(load_val[3:0],   DIGIT_MAX);

   bcd_down_digit #(.WRAP(DIGIT_MAX)) u_sec_lo (
      .clk(clk), .rst_n(rst_n), .load(load_en), .load_d(ld_sl),
      .dec_en(dec), .digit(sec_lo), .borrow(bo_sl)
   );

   bcd_down_digit #(.WRAP(SEC_TENS_MAX)) u_sec_hi (
      .clk(clk), .rst_n(rst_n), .load(load_en), .load_d(ld_sh),
      .dec_en(bo_sl), .digit(sec_hi), .borrow(bo_sh)
   );

   bcd_down_digit #(.WRAP(DIGIT_MAX)) u_min_lo (
      .clk(clk), .rst_n(rst_n), .load(load_en), .load_d(ld_ml),
      .dec_en(bo_sh), .digit(min_lo), .borrow(bo_ml)
   );

   bcd_down_digit #(.WRAP(DIGIT_MAX)) u_min_hi (
      .clk(clk), .rst_n(rst_n), .load(load_en), .load_d(ld_mh),
      .dec_en(bo_ml), .digit(min_hi), .borrow(bo_mh)
   );

   always_comb begin
      state_nx = state;
      if (load_en) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (start && !is_zero) state_nx = RUN;
            RUN: begin
               if (pause)                     state_nx = PAUSED;
               else if (tick && (is_one || bo_mh)) state_nx = DONE;
            end
            PAUSED:  if (start) state_nx = RUN;
            DONE:    state_nx = DONE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // flags are registered so every output changes only on a clock edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         running <= 1'b0;
         min_bo  <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         running <= (state_nx == RUN);
         min_bo  <= bo_sh;
         done    <= (state == RUN) && (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_countdown_mmss.sv
// tb/tb_countdown_mmss.sv - self-checking bench for countdown_mmss against a seconds-count model
module tb_countdown_mmss;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
   logic [15:0] load_val = 16'h0000;
   logic [3:0]  min_hi, min_lo, sec_hi, sec_lo;
   logic        running, min_bo, done;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
   int m_secs  = 0;
   int m_state = S_IDLE;
   bit m_bo    = 1'b0;
   bit m_done  = 1'b0;

   countdown_mmss dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .min_hi(min_hi), .min_lo(min_lo),
      .sec_hi(sec_hi), .sec_lo(sec_lo), .running(running), .min_bo(min_bo),
      .done(done)
   );

   always #5 clk = ~clk;

   function automatic int clampi(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic int sanitize(input logic [15:0] v);
      int mh, ml, sh, sl;
      mh = clampi(int'(v[15:12]), 9);
      ml = clampi(int'(v[11:8]), 9);
      sh = clampi(int'(v[7:4]), 5);
      sl = clampi(int'(v[3:0]), 9);
      return (mh * 10 + ml) * 60 + sh * 10 + sl;
   endfunction

   function automatic logic [15:0] to_bcd(input int s);
      int m, ss;
      m  = s / 60;
      ss = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // reference: value kept as total seconds, outputs derived arithmetically
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_secs  <= 0;
         m_state <= S_IDLE;
         m_bo    <= 1'b0;
         m_done  <= 1'b0;
      end else begin
         m_bo   <= 1'b0;
         m_done <= 1'b0;
         if (load && m_state != S_RUN) begin
            m_secs  <= sanitize(load_val);
            m_state <= S_IDLE;
         end else if (m_state == S_IDLE) begin
            if (start && m_secs != 0) m_state <= S_RUN;
         end else if (m_state == S_PAUSED) begin
            if (start) m_state <= S_RUN;
         end else if (m_state == S_RUN) begin
            if (pause) begin
               m_state <= S_PAUSED;
            end else if (tick) begin
               m_bo   <= (m_secs % 60 == 0);
               m_secs <= m_secs - 1;
               if (m_secs == 1) begin
                  m_state <= S_DONE;
                  m_done  <= 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         n_checks++;
         if ({min_hi, min_lo, sec_hi, sec_lo, running, min_bo, done} ===
             {to_bcd(m_secs), (m_state == S_RUN), m_bo, m_done}) begin
            n_pass++;
         end else begin
            $display("FAIL model t=%0t got digits=%h run=%b bo=%b done=%b want digits=%h run=%b bo=%b done=%b",
                     $time, {min_hi, min_lo, sec_hi, sec_lo}, running, min_bo, done,
                     to_bcd(m_secs), (m_state == S_RUN), m_bo, m_done);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s got=%h want=%h", name, act, exp);
   endtask

   task automatic cyc(input logic t, input logic l, input logic s, input logic p,
                      input logic [15:0] v);
      tick = t; load = l; start = s; pause = p; load_val = v;
      @(negedge clk);
      tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
   endtask

   function automatic logic [15:0] digs();
      return {min_hi, min_lo, sec_hi, sec_lo};
   endfunction

   logic [15:0] exp_seq [4];

   initial begin
      exp_seq[0] = 16'h0102; exp_seq[1] = 16'h0101;
      exp_seq[2] = 16'h0100; exp_seq[3] = 16'h0059;
      cyc(0, 0, 0, 0, 16'h0);
      cyc(0, 0, 0, 0, 16'h0);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      check("reset_digits", 32'(digs()), 32'h0);
      check("reset_flags", {29'd0, running, min_bo, done}, 32'h0);

      cyc(0, 0, 1, 0, 16'h0);
      check("start_at_zero", {31'd0, running}, 32'h0);

      cyc(0, 1, 0, 0, 16'h0103);
      check("load_0103", 32'(digs()), 32'h0103);
      cyc(1, 0, 1, 0, 16'h0);
      check("start_tick_ignored", {15'd0, digs(), 1'b0, running}, {15'd0, 16'h0103, 1'b0, 1'b1});
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 0, 0, 16'h0);
         check("tick_seq", 32'(digs()), 32'(exp_seq[i]));
         check("min_bo_seq", {31'd0, min_bo}, (i == 3) ? 32'd1 : 32'd0);
      end
      cyc(0, 0, 0, 0, 16'h0);
      check("min_bo_one_cycle", {31'd0, min_bo}, 32'd0);

      cyc(0, 0, 0, 1, 16'h0);
      cyc(0, 1, 0, 0, 16'h0002);
      check("load_0002", 32'(digs()), 32'h0002);
      cyc(0, 0, 1, 0, 16'h0);
      cyc(1, 0, 0, 0, 16'h0);
      cyc(1, 0, 0, 0, 16'h0);
      check("done_value", {digs(), 13'd0, running, min_bo, done}, {16'h0000, 16'h0001});
      cyc(1, 0, 1, 0, 16'h0);
      check("after_done", {digs(), 13'd0, running, min_bo, done}, 32'h0);

      cyc(0, 1, 0, 0, 16'hFF7F);
      check("sanitise", 32'(digs()), 32'h9959);

      cyc(0, 1, 0, 0, 16'h0030);
      cyc(0, 0, 1, 0, 16'h0);
      cyc(1, 0, 0, 1, 16'h0);
      check("pause_beats_tick", {digs(), 15'd0, running}, {16'h0030, 16'h0000});
      cyc(1, 0, 0, 0, 16'h0);
      check("paused_tick", 32'(digs()), 32'h0030);
      cyc(0, 0, 1, 0, 16'h0);
      cyc(1, 0, 0, 0, 16'h0);
      check("resume_tick", {digs(), 15'd0, running}, {16'h0029, 16'h0001});
      cyc(1, 1, 0, 0, 16'h0500);
      check("load_in_run", {digs(), 15'd0, running}, {16'h0028, 16'h0001});
      cyc(0, 0, 0, 1, 16'h0);
      cyc(0, 1, 0, 0, 16'h0500);
      check("load_paused", {digs(), 15'd0, running}, {16'h0500, 16'h0000});

      cyc(0, 1, 0, 0, 16'h1234);
      cyc(0, 0, 1, 0, 16'h0);
      cyc(1, 0, 0, 0, 16'h0);
      check("pre_reset", 32'(digs()), 32'h1233);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset", {digs(), 13'd0, running, min_bo, done}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         logic [15:0] v;
         v = 16'($urandom);
         if ($urandom_range(1, 0) == 1) v = v & 16'h003F;
         cyc(($urandom_range(1, 0) == 1), ($urandom_range(99, 0) < 5),
             ($urandom_range(99, 0) < 15), ($urandom_range(99, 0) < 5), v);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
